// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with registered one-hot grant and a one-cycle turnaround.
// Define RR_ARB_TIMEOUT_EN to revoke a grant after HOLD_MAX cycles and pulse timeout.
module rr_arbiter_4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic       timeout_q, timeout_d;
  logic [1:0] last_q, last_d;
  logic [7:0] hold_q, hold_d;

  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       rel;
  logic       hold_hit;
  logic       revoke;

  // Search order last+1, last+2, last+3, last; first asserted request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign rel      = (state_q == StGrant) && (done || !req[gnt_idx_q]);
  assign hold_hit = (hold_q == 8'(HOLD_MAX - 1));

`ifdef RR_ARB_TIMEOUT_EN
  // A normal release in the same cycle takes precedence over the timeout.
  assign revoke = (state_q == StGrant) && !rel && hold_hit;
`else
  logic unused_hold;
  assign unused_hold = hold_hit;
  assign revoke      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      last_q      <= 2'd3;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (win_found) state_d = StGrant;
      StGrant: if (rel || revoke) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt_d       = '0;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = 1'b0;
    timeout_d   = revoke;
    last_d      = last_q;
    hold_d      = hold_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          gnt_d       = 4'b0001 << win_idx;
          gnt_idx_d   = win_idx;
          gnt_valid_d = 1'b1;
          last_d      = win_idx;
          hold_d      = '0;
        end
      end
      StGrant: begin
        hold_d = hold_q + 8'd1;
        if (!(rel || revoke)) begin
          gnt_d       = gnt_q;
          gnt_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: vector table plus timeout and async-reset sequences.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  rr_arbiter_4 #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
  } vec_t;

  vec_t vecs[22];

`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  task automatic chk(input string name, input logic [3:0] eg, input logic [1:0] ei,
                     input logic ev, input logic et);
    logic [1:0] dec_idx;
    checks++;
    if (gnt !== eg || gnt_idx !== ei || gnt_valid !== ev || timeout !== et) begin
      errors++;
      $display("FAIL %s: got gnt=%b idx=%0d valid=%b timeout=%b, want gnt=%b idx=%0d valid=%b timeout=%b",
               name, gnt, gnt_idx, gnt_valid, timeout, eg, ei, ev, et);
    end
    // Structural invariant that must hold every cycle.
    checks++;
    dec_idx = gnt_idx;
    if ((gnt_valid !== (gnt != 4'b0)) || ($countones(gnt) > 1) ||
        (gnt_valid && gnt !== (4'b0001 << dec_idx))) begin
      errors++;
      $display("FAIL %s invariant: got gnt=%b idx=%0d valid=%b, want consistent one-hot",
               name, gnt, gnt_idx, gnt_valid);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            req      done gnt      idx  valid
    vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0};
    vecs[2]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1};
    vecs[3]  = '{4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0};
    vecs[4]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1};
    vecs[5]  = '{4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0};
    vecs[6]  = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1};
    vecs[7]  = '{4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0};
    vecs[8]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};
    vecs[9]  = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0};
    vecs[10] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
    vecs[11] = '{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0};
    vecs[12] = '{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0};
    vecs[13] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1};
    vecs[14] = '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1};
    vecs[15] = '{4'b1010, 1'b1, 4'b0000, 2'd1, 1'b0};
    vecs[16] = '{4'b1010, 1'b0, 4'b1000, 2'd3, 1'b1};
    vecs[17] = '{4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0};
    vecs[18] = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1};
    vecs[19] = '{4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0};
    vecs[20] = '{4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1};
    vecs[21] = '{4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0};

    rst  = 1'b1;
    req  = 4'b0;
    done = 1'b0;
    #1;
    chk("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(4'b0000, 1'b0);
    chk("idle_no_req", 4'b0000, 2'd0, 1'b0, 1'b0);

    for (int i = 0; i < 22; i++) begin
      step(vecs[i].req, vecs[i].done);
      chk($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx, vecs[i].valid, 1'b0);
    end

    // Hold requester 0 with done low; last pointer is 1 here.
    step(4'b0001, 1'b0);
    chk("hold_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      step(4'b0001, 1'b0);
      chk($sformatf("hold_c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    step(4'b0001, 1'b0);
    if (TimeoutEn) chk("timeout_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
    else           chk("no_timeout", 4'b0001, 2'd0, 1'b1, 1'b0);
    step(4'b0001, 1'b0);
    chk("regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
    step(4'b0000, 1'b0);
    chk("hold_release", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Last is 0, so requester 3 wins; then reset mid-cycle.
    step(4'b1001, 1'b0);
    chk("pre_reset_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("reset_held", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step(4'b1001, 1'b0);
    chk("post_reset_prio0", 4'b0001, 2'd0, 1'b1, 1'b0);
    step(4'b0000, 1'b0);
    chk("post_reset_release", 4'b0000, 2'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4.md
RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 Parameter: HOLD_MAX, default 8, maximum grant length in cycles when timeout is compiled in (legal 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  4  request lines; req[i] high = requester i wants the shared resource.
REQ-005 done  input  1  current grant holder releases the resource; sampled only in GRANT.
REQ-006 gnt  output  4  registered one-hot grant; all zero when no grant.
REQ-007 gnt_idx  output  2  registered binary index of the granted requester; gnt equals 2-to-4 decode of gnt_idx whenever gnt_valid=1.
REQ-008 gnt_valid  output  1  registered; high exactly when gnt is non-zero.
REQ-009 timeout  output  1  registered one-cycle pulse on forced revocation.

Function
REQ-010 The FSM SHALL have exactly two states, IDLE and GRANT.
REQ-011 In IDLE with req==0, the FSM SHALL stay in IDLE with gnt=0, gnt_valid=0.
REQ-012 In IDLE with req!=0, at the rising edge the winner SHALL be chosen and the FSM SHALL enter GRANT; gnt/gnt_idx/gnt_valid valid after that same edge (1-cycle latency from sampled req).
REQ-013 Winner selection SHALL be round-robin: search order last+1, last+2, last+3, last (mod 4), where last is the pointer of the most recent grant; first set req bit in that order wins.
REQ-014 The pointer last SHALL update to the winner's index at the edge that issues the grant.
REQ-015 In GRANT, gnt SHALL stay constant regardless of other req changes.
REQ-016 In GRANT, release SHALL occur at an edge where done=1 or req[gnt_idx]=0; after that edge gnt=0, gnt_valid=0, state IDLE.
REQ-017 After any release, the FSM SHALL spend exactly one cycle in IDLE (turnaround) before a new grant; back-to-back grants are therefore separated by one dead cycle.
REQ-018 gnt_idx SHALL hold its last value while gnt_valid=0.
REQ-019 A hold counter (8 bits) SHALL clear on entry to GRANT and increment each cycle in GRANT.
REQ-020 Simultaneous done and timeout condition SHALL be treated as a normal release; timeout SHALL NOT pulse.
REQ-021 A requester re-raising req during the turnaround cycle SHALL be arbitrated normally; it wins again only if no other req bit is set ahead of it in the search order.

Reset
REQ-022 Asserting rst SHALL immediately (asynchronously) force state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, counter=0, last=3 (so requester 0 has first priority).
REQ-023 Reset asserted mid-grant SHALL drop gnt without waiting for clk; arbitration resumes at the first rising edge after rst deasserts.

Configuration
REQ-024 Macro RR_ARB_TIMEOUT_EN SHALL control forced revocation.
REQ-025 With RR_ARB_TIMEOUT_EN defined: at the edge where counter==HOLD_MAX-1 in GRANT without release, the grant SHALL be revoked (state IDLE, gnt=0) and timeout SHALL be high for the following cycle only; max grant length = HOLD_MAX cycles.
REQ-026 Without RR_ARB_TIMEOUT_EN: grants last until release only, timeout SHALL be constant 0, counter logic MAY be omitted; port list unchanged.

Verification
REQ-027 After reset, req=4'b1111 held -> grants in order gnt=0001,0010,0100,1000,0001, done pulsed 1 cycle each grant, one idle cycle between.
REQ-028 req=4'b0100 asserted at edge N -> gnt=0100, gnt_idx=2, gnt_valid=1 after edge N; req[2] dropped -> gnt=0 after next edge.
REQ-029 Holder 1 granted, req[3] raised during grant -> gnt stays 0010 until done; then gnt=1000 after the turnaround cycle.
REQ-030 With RR_ARB_TIMEOUT_EN, HOLD_MAX=4, req=4'b0001 held, done=0 -> gnt=0001 for exactly 4 cycles, then timeout=1 for 1 cycle, regrant 0001 after turnaround; without macro gnt stays 0001 and timeout=0.
REQ-031 rst asserted between clock edges during grant -> gnt=0000, gnt_valid=0 immediately; after release with req=4'b1001 -> gnt=0001 first.
REQ-032 Every cycle: gnt_valid==(gnt!=0), gnt one-hot or zero, gnt==decode(gnt_idx) when gnt_valid.
